// File: rtl/seven_segment_scan.sv
// seven_segment_scan: time-multiplexed driver for a common-anode hex display.
// A pending/active register pair keeps the shown value stable for the whole
// frame. Each digit gets one slot of DIV cycles. During the first GAP cycles of
// a slot every anode is off. All pin-facing outputs are registered.

module seven_segment_scan #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000,
    parameter int GAP    = 500
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame_done
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_CNT = CW'(GAP);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    // Active-low glyphs, bit6 = g down to bit0 = a.
    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            4'hF:    g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    logic [CW-1:0]         cnt_r;
    logic [IW-1:0]         idx_r;
    logic [4*DIGITS-1:0]   act_value_r;
    logic [DIGITS-1:0]     act_dp_r;
    logic [DIGITS-1:0]     act_blank_r;
    logic [4*DIGITS-1:0]   pend_value_r;
    logic [DIGITS-1:0]     pend_dp_r;
    logic [DIGITS-1:0]     pend_blank_r;
    logic                  pending_r;
    logic [6:0]            seg_r;
    logic                  dp_n_r;
    logic [DIGITS-1:0]     an_r;
    logic                  frame_done_r;

    logic                  slot_end_s;
    logic                  boundary_s;
    logic [3:0]            nib_s;
    logic                  cur_dp_s;
    logic                  cur_blank_s;
    logic                  supp_s;
    logic                  nz_above_s;
    logic                  dark_s;
    logic [6:0]            seg_nxt_s;
    logic                  dp_n_nxt_s;
    logic [DIGITS-1:0]     an_nxt_s;

    assign slot_end_s = (cnt_r == CNT_MAX);
    assign boundary_s = slot_end_s && (idx_r == IDX_MAX);

    // Slot counter and digit index; the index steps once per slot wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
            idx_r <= '0;
        end else if (slot_end_s) begin
            cnt_r <= '0;
            if (idx_r == IDX_MAX) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + IW'(1);
            end
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    // Double buffer. A load on the boundary cycle goes straight to active.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_value_r  <= '0;
            act_dp_r     <= '0;
            act_blank_r  <= '1;
            pend_value_r <= '0;
            pend_dp_r    <= '0;
            pend_blank_r <= '1;
            pending_r    <= 1'b0;
        end else if (boundary_s) begin
            if (load) begin
                act_value_r <= value;
                act_dp_r    <= dp;
                act_blank_r <= blank;
            end else if (pending_r) begin
                act_value_r <= pend_value_r;
                act_dp_r    <= pend_dp_r;
                act_blank_r <= pend_blank_r;
            end else begin
                act_value_r <= act_value_r;
            end
            pending_r <= 1'b0;
        end else if (load) begin
            pend_value_r <= value;
            pend_dp_r    <= dp;
            pend_blank_r <= blank;
            pending_r    <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Select the scanned digit. Work out leading-zero suppression from the MSD
    // downward; the blank bits are ignored here.
    always_comb begin
        nib_s       = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b1;
        supp_s      = 1'b0;
        nz_above_s  = 1'b0;
        an_nxt_s    = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_above_s = nz_above_s | (act_value_r[4*i +: 4] != 4'h0);
            if (IW'(i) == idx_r) begin
                nib_s       = act_value_r[4*i +: 4];
                cur_dp_s    = act_dp_r[i];
                cur_blank_s = act_blank_r[i];
                supp_s      = lz_en & (i != 0) & ~nz_above_s;
                an_nxt_s[i] = ~(cnt_r >= GAP_CNT);
            end else begin
                an_nxt_s[i] = 1'b1;
            end
        end
    end

    // Decode the segments and decimal point, or force them dark.
    always_comb begin
        dark_s     = cur_blank_s | supp_s;
        seg_nxt_s  = 7'b1111111;
        dp_n_nxt_s = 1'b1;
        if (dark_s) begin
            seg_nxt_s  = 7'b1111111;
            dp_n_nxt_s = 1'b1;
        end else begin
            seg_nxt_s  = hex_glyph(nib_s);
            dp_n_nxt_s = ~cur_dp_s;
        end
    end

    // Output registers; reset drives the display dark at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_r        <= 7'b1111111;
            dp_n_r       <= 1'b1;
            an_r         <= '1;
            frame_done_r <= 1'b0;
        end else begin
            seg_r        <= seg_nxt_s;
            dp_n_r       <= dp_n_nxt_s;
            an_r         <= an_nxt_s;
            frame_done_r <= boundary_s;
        end
    end

    assign seg        = seg_r;
    assign dp_n       = dp_n_r;
    assign an         = an_r;
    assign pending    = pending_r;
    assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Bench for seven_segment_scan with DIGITS=4, DIV=4, GAP=1 (16-cycle frame).
// The reference model keeps only a free-running cycle count since reset. It
// derives the slot and digit from that count arithmetically, and holds the
// active/pending data as plain variables.

module tb_seven_segment_scan;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int GAP    = 1;
    localparam int FRAME  = DIGITS * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        lz_en;
    logic [6:0]  seg;
    logic        dp_n;
    logic [3:0]  an;
    logic        pending;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    int          t;
    logic [15:0] a_val, p_val;
    logic [3:0]  a_dp, p_dp, a_bl, p_bl;
    logic        p_flag;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seven_segment_scan #(.DIGITS(DIGITS), .DIV(DIV), .GAP(GAP)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .value      (value),
        .dp         (dp),
        .blank      (blank),
        .lz_en      (lz_en),
        .seg        (seg),
        .dp_n       (dp_n),
        .an         (an),
        .pending    (pending),
        .frame_done (frame_done)
    );

    // free-running clock
    always #5 clk = ~clk;

    // watchdog so the run always ends
    initial begin
        #2000000;
        $display("FAIL watchdog expired at t=%0d", t);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_reset();
        t      = 0;
        a_val  = 16'h0000; a_dp = 4'h0; a_bl = 4'hF;
        p_val  = 16'h0000; p_dp = 4'h0; p_bl = 4'hF;
        p_flag = 1'b0;
    endtask

    task automatic check_dark(input string tag);
        check({tag, "_seg"}, 32'(seg), 32'h7F);
        check({tag, "_dpn"}, 32'(dp_n), 32'h1);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_pend"}, 32'(pending), 32'h0);
        check({tag, "_fd"}, 32'(frame_done), 32'h0);
    endtask

    // Hold reset for a cycle, check the reset state, then release at negedge.
    task automatic reset_dut();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_dark("rst");
        rst = 1'b0;
    endtask

    // One clock: drive inputs, predict the registered outputs, then compare.
    task automatic tick(input logic ld, input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
        int          dig, c;
        logic        dark;
        logic [3:0]  nib;
        logic [6:0]  e_seg;
        logic        e_dpn;
        logic [3:0]  e_an;
        logic        e_fd;
        load  = ld;
        value = v;
        dp    = d;
        blank = b;
        dig   = (t / DIV) % DIGITS;
        c     = t % DIV;
        nib   = 4'(a_val >> (4 * dig));
        dark  = a_bl[dig] || (lz_en && dig != 0 && (a_val >> (4 * dig)) == 16'h0);
        e_seg = dark ? 7'h7F : glyph_tab[nib];
        e_dpn = dark ? 1'b1 : ~a_dp[dig];
        e_an  = (c >= GAP) ? ~(4'b0001 << dig) : 4'hF;
        e_fd  = (t % FRAME) == FRAME - 1;
        if (e_fd) begin
            if (ld) begin
                a_val = v; a_dp = d; a_bl = b;
            end else if (p_flag) begin
                a_val = p_val; a_dp = p_dp; a_bl = p_bl;
            end
            p_flag = 1'b0;
        end else if (ld) begin
            p_val = v; p_dp = d; p_bl = b; p_flag = 1'b1;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        check("seg", 32'(seg), 32'(e_seg));
        check("dp_n", 32'(dp_n), 32'(e_dpn));
        check("an", 32'(an), 32'(e_an));
        check("pending", 32'(pending), 32'(p_flag));
        check("frame_done", 32'(frame_done), 32'(e_fd));
    endtask

    // Idle cycles; random data on the inputs must be ignored without load.
    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            tick(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
        end
    endtask

    task automatic run_to(input int pos);
        for (int k = 0; k < FRAME && (t % FRAME) != pos; k++) begin
            idle(1);
        end
    endtask

    initial begin
        rst   = 1'b1;
        load  = 1'b0;
        value = 16'h0;
        dp    = 4'h0;
        blank = 4'h0;
        lz_en = 1'b0;
        model_reset();
        @(negedge clk);
        reset_dut();

        // first load and a frame of 1234
        tick(1'b1, 16'h1234, 4'h0, 4'h0);
        idle(31);

        // glyph sweep
        tick(1'b1, 16'hFEDC, 4'h0, 4'h0); idle(31);
        tick(1'b1, 16'hBA98, 4'hF, 4'h0); idle(31);
        tick(1'b1, 16'h7654, 4'h0, 4'h0); idle(31);
        tick(1'b1, 16'h3210, 4'h5, 4'h0); idle(31);

        // last load wins; load on the boundary goes straight to active
        run_to(0);
        tick(1'b1, 16'h1111, 4'h0, 4'h0);
        idle(2);
        tick(1'b1, 16'h2222, 4'h0, 4'h0);
        run_to(FRAME - 1);
        idle(FRAME);
        tick(1'b1, 16'h3333, 4'h0, 4'h0);
        idle(FRAME);

        // leading-zero suppression and blanking
        lz_en = 1'b1;
        tick(1'b1, 16'h0040, 4'b1001, 4'h0); idle(31);
        lz_en = 1'b0;
        idle(FRAME);
        lz_en = 1'b1;
        tick(1'b1, 16'h0000, 4'b1001, 4'h0); idle(31);
        tick(1'b1, 16'h0000, 4'b1001, 4'b0001); idle(31);
        tick(1'b1, 16'h5000, 4'b1111, 4'b1000); idle(31);

        // randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(19) == 0) lz_en = ~lz_en;
            tick(($urandom_range(5) == 0), 16'($urandom), 4'($urandom),
                 4'($urandom & $urandom & $urandom));
        end

        // reset in the middle of a frame with a load pending
        lz_en = 1'b0;
        tick(1'b1, 16'hABCD, 4'b0101, 4'h0);
        run_to(0);
        run_to(3);
        tick(1'b1, 16'h5555, 4'hF, 4'h0);
        run_to(10);
        #2;
        rst = 1'b1;
        #1;
        check_dark("async_rst");
        reset_dut();
        idle(40);
        tick(1'b1, 16'h9876, 4'h2, 4'h0);
        idle(32);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
